// File: rtl/seg7_pkg.sv
// Shared seven-segment constants for the scan driver and its decoder.
// Segment order is {a,b,c,d,e,f,g}, a in the MSB, logical polarity (1 = lit).
package seg7_pkg;

    localparam logic [6:0] SEG7_DIGIT [0:9] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011   // 9
    };

    localparam logic [6:0] SEG7_BLANK = 7'b0000000;
    localparam logic [6:0] SEG7_ALL   = 7'b1111111;

    // Largest digit count the scan driver supports.
    localparam int SEG7_MAX_DIGITS = 8;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder; codes 10..15 decode to blank.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Table lookup over the valid BCD codes, blank otherwise.
    always_comb begin
        seg = SEG7_BLANK;
        for (int unsigned i = 0; i < 10; i++) begin
            if (code == 4'(i)) begin
                seg = SEG7_DIGIT[i];
            end
        end
    end

endmodule

// File: rtl/bcd_7seg_scan_driver.sv
// Multiplexed N-digit BCD to seven-segment scan driver with input latch,
// lamp test, blanking and selectable pin polarity.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module bcd_7seg_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] bcd,
    input  logic                  load,
    input  logic                  lt,
    input  logic                  bl,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_tick
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [N_DIGITS-1:0][3:0] digit_q;
    logic [DIV_W-1:0]         div;
    logic [IDX_W-1:0]         idx;
    logic                     tc;
    logic [3:0]               cur_digit;
    logic [6:0]               dec_seg;
    logic                     cur_blank;
    logic [6:0]               seg_d;
    logic [N_DIGITS-1:0]      an_d;
    logic [6:0]               seg_q;
    logic [N_DIGITS-1:0]      an_q;
    logic                     frame_q;

    // Input latch: capture the packed BCD word on load, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= '0;
        end else if (load) begin
            digit_q <= bcd;
        end
    end

    assign tc = (div == DIV_LAST);

    // Refresh divider and scan index; the index steps once per terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
        end else if (tc) begin
            div <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Select the active digit and build its one-hot enable.
    always_comb begin
        cur_digit = '0;
        an_d      = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_digit = digit_q[k];
                an_d[k]   = 1'b1;
            end
        end
    end

    bcd_to_seg7 u_dec (
        .code (cur_digit),
        .seg  (dec_seg)
    );

`ifdef SEG7_LZB_EN
    logic [N_DIGITS-1:0] lz_mask;
    logic                higher_nz;

    // Leading-zero mask: a digit is dark when it and every digit above it are
    // zero; digit 0 always shows. Any nonzero code, valid or not, stops blanking.
    always_comb begin
        lz_mask   = '0;
        higher_nz = 1'b0;
        cur_blank = bl;
        for (int unsigned j = 1; j < N_DIGITS; j++) begin
            higher_nz                = higher_nz | (digit_q[N_DIGITS-j] != 4'd0);
            lz_mask[N_DIGITS-j]      = ~higher_nz;
        end
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k) && lz_mask[k]) begin
                cur_blank = 1'b1;
            end
        end
    end
`else
    assign cur_blank = bl;
`endif

    // Segment priority: lamp test, then blanking, then the decoded digit.
    always_comb begin
        seg_d = dec_seg;
        if (lt) begin
            seg_d = SEG7_ALL;
        end else if (cur_blank) begin
            seg_d = SEG7_BLANK;
        end
    end

    // Output stage: seg and an update together so digits never ghost.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q   <= SEG7_BLANK;
            an_q    <= '0;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= tc && (idx == IDX_LAST);
        end
    end

    assign seg        = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign an         = (AN_ACTIVE_LOW != 0) ? ~an_q : an_q;
    assign frame_tick = frame_q;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Self-checking bench for bcd_7seg_scan_driver: three instances share stimulus
// (4 digits default polarity, 4 digits inverted polarity, 1 digit) and are
// compared against a cycle-count based reference model.
module tb_bcd_7seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        lt = 1'b0;
    logic        bl = 1'b0;
    logic [15:0] bcd = 16'h0000;

    logic [6:0]  seg_a, seg_b, seg_c;
    logic [3:0]  an_a, an_b;
    logic        an_c;
    logic        ft_a, ft_b, ft_c;

    int vectors = 0;
    int miscompares = 0;

    // Model state: cycles since reset release and the latched digits.
    int cnt = 0;
    int dig [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    bcd_7seg_scan_driver #(
        .N_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
    ) dut_a (
        .clk(clk), .rst(rst), .bcd(bcd), .load(load), .lt(lt), .bl(bl),
        .seg(seg_a), .an(an_a), .frame_tick(ft_a)
    );

    bcd_7seg_scan_driver #(
        .N_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(0)
    ) dut_b (
        .clk(clk), .rst(rst), .bcd(bcd), .load(load), .lt(lt), .bl(bl),
        .seg(seg_b), .an(an_b), .frame_tick(ft_b)
    );

    bcd_7seg_scan_driver #(
        .N_DIGITS(1), .REFRESH_DIV(3), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
    ) dut_c (
        .clk(clk), .rst(rst), .bcd(bcd[3:0]), .load(load), .lt(lt), .bl(bl),
        .seg(seg_c), .an(an_c), .frame_tick(ft_c)
    );

    function automatic logic [6:0] dec(int v);
        case (v)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // True when the digit at pos sits above the most significant nonzero digit.
    function automatic bit lz_blank(int pos);
`ifdef SEG7_LZB_EN
        int h = 0;
        for (int i = 0; i < 4; i++) begin
            if (dig[i] != 0) h = i;
        end
        return pos > h;
`else
        return (pos < 0);
`endif
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: predict outputs from the pre-edge model state, advance the
    // model, then sample the DUTs just after the edge.
    task automatic tick();
        int          pos;
        logic [6:0]  s_a, s_c, s_b_pin;
        logic [3:0]  e_an, an_a_pin;
        logic        e_ft_a, e_ft_c, e_an_c, an_c_pin;
        if (rst) begin
            s_a = 7'b0; s_c = 7'b0; e_an = 4'b0;
            e_ft_a = 1'b0; e_ft_c = 1'b0; e_an_c = 1'b0;
        end else begin
            pos = (cnt / 4) % 4;
            s_a = dec(dig[pos]);
            if (lz_blank(pos)) s_a = 7'b0;
            if (bl) s_a = 7'b0;
            if (lt) s_a = 7'b1111111;
            e_an   = 4'(1 << pos);
            e_ft_a = ((cnt % 16) == 15);
            s_c = dec(dig[0]);
            if (bl) s_c = 7'b0;
            if (lt) s_c = 7'b1111111;
            e_an_c = 1'b1;
            e_ft_c = ((cnt % 3) == 2);
        end
        if (rst) begin
            cnt = 0;
            for (int k = 0; k < 4; k++) dig[k] = 0;
        end else begin
            cnt++;
            if (load) begin
                for (int k = 0; k < 4; k++) dig[k] = int'(bcd[4*k +: 4]);
            end
        end
        an_a_pin = ~e_an;
        s_b_pin  = ~s_a;
        an_c_pin = ~e_an_c;
        @(posedge clk);
        #1;
        check("seg_a", 16'(seg_a), 16'(s_a));
        check("an_a",  16'(an_a),  16'(an_a_pin));
        check("ft_a",  16'(ft_a),  16'(e_ft_a));
        check("seg_b", 16'(seg_b), 16'(s_b_pin));
        check("an_b",  16'(an_b),  16'(e_an));
        check("ft_b",  16'(ft_b),  16'(e_ft_a));
        check("seg_c", 16'(seg_c), 16'(s_c));
        check("an_c",  16'(an_c),  16'(an_c_pin));
        check("ft_c",  16'(ft_c),  16'(e_ft_c));
    endtask

    initial begin
        // Reset state.
        tick();
        tick();
        check("reset_an_pins", 16'(an_a), 16'h000F);
        check("reset_seg",     16'(seg_a), 16'h0000);

        // Release reset and latch 1234; watch two full frames.
        rst  = 1'b0;
        bcd  = 16'h1234;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 32; i++) tick();

        // Input changes without load must not show.
        bcd = 16'h9999;
        for (int i = 0; i < 16; i++) tick();

        // Load on a terminal-count cycle; next digit shows 9.
        for (int i = 0; i < 4 && (cnt % 4) != 3; i++) tick();
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check("tc_load_next_digit", 16'(seg_a), 16'h007B);
        for (int i = 0; i < 14; i++) tick();

        // Invalid codes in the low digits.
        bcd  = 16'h00AF;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        // Blank, then lamp test overriding blank, then lamp test alone.
        bcd  = 16'h5678;
        load = 1'b1;
        tick();
        load = 1'b0;
        bl = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        lt = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        bl = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        lt = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Leading-zero patterns.
        bcd  = 16'h0000;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        bcd  = 16'h0100;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 16; i++) tick();

        // Randomized traffic, zero-biased so blanking patterns occur.
        for (int i = 0; i < 240; i++) begin
            logic [15:0] r;
            r = 16'($urandom);
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 2) == 0) r[4*k +: 4] = 4'h0;
            end
            bcd  = r;
            load = ($urandom_range(0, 5) == 0);
            lt   = ($urandom_range(0, 15) == 0);
            bl   = ($urandom_range(0, 11) == 0);
            tick();
        end
        load = 1'b0;
        lt   = 1'b0;
        bl   = 1'b0;

        // Reset asserted while digit 2 is being selected.
        for (int i = 0; i < 16 && ((cnt / 4) % 4) != 2; i++) tick();
        rst = 1'b1;
        tick();
        check("midscan_reset_dark", 16'(an_a), 16'h000F);
        rst = 1'b0;
        tick();
        check("release_digit0_lit", 16'(an_a), 16'h000E);
        for (int i = 0; i < 20; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
